// File: rtl/subtractor_bitserial_ctrl.sv
// -----------------------------------------------------------------------------
// subtractor_bitserial_ctrl
//
// Bit-serial subtract sequencer. It accepts one WIDTH-bit operand pair over a
// valid/ready handshake. It then computes A - B with a single 1-bit
// full-subtractor, one bit per cycle, LSB first. The result is returned over a
// second valid/ready handshake.
//
// Optional feature macro: SUB_SEQ_BORROW_OUT_EN
//   When defined, the Bout port exists. It carries the final borrow (A < B)
//   alongside Sub.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block can accept operands (IDLE only)
//   A, B       minuend / subtrahend, sampled on the input handshake
//   out_valid  Sub (and Bout) hold a completed result
//   out_ready  consumer accepts the result
//   Sub        result register; shifts visibly during RUN
//   busy       high while in RUN or DONE
//   Bout       final borrow (only with SUB_SEQ_BORROW_OUT_EN)
// -----------------------------------------------------------------------------
module subtractor_bitserial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sub,
  output logic             busy
`ifdef SUB_SEQ_BORROW_OUT_EN
  ,
  output logic             Bout
`endif
);

  // The counter only has to reach WIDTH-1. Keep at least one bit so that
  // WIDTH=1 still yields a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sub_q;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             a0;
  logic             b0;
  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] sub_next;
  logic             last_bit;

  // One full-subtractor slice operates on the current LSBs.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through the block can infer a latch.
    sub_next           = sub_q >> 1;
    a0                 = a_sr[0];
    b0                 = b_sr[0];
    d                  = a0 ^ b0 ^ borrow;
    borrow_next        = (~a0 & b0) | (~(a0 ^ b0) & borrow);
    // The new bit enters at the MSB, so after WIDTH shifts the LSB-first
    // results are in their correct positions. This form also holds for WIDTH=1.
    sub_next[WIDTH-1]  = d;
    last_bit           = (count == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sub_q  <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= 1'b0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sub_q  <= sub_next;
          borrow <= borrow_next;
          count  <= count + CW'(1);
          if (last_bit) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Sub and borrow stay frozen until the consumer takes the result.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB_SEQ_BORROW_OUT_EN
  // Bout keeps its previous value during RUN. It is loaded only on the final
  // RUN cycle, so it shows the new borrow at the same moment out_valid rises.
  logic bout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bout_q <= 1'b0;
    end else if (state == RUN && last_bit) begin
      bout_q <= borrow_next;
    end
  end

  assign Bout = bout_q;
`endif

  // Handshake and status outputs are decoded from the state register only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign Sub       = sub_q;

endmodule

// File: doc/subtractor_bitserial_ctrl.md
# subtractor_bitserial_ctrl

Bit-serial subtract sequencer: accepts one WIDTH-bit operand pair over a valid/ready handshake and computes A − B with a single 1-bit full-subtractor datapath, one bit per cycle, LSB first. It owns the borrow flop, bit counter and operand/result shift registers. It returns the result over a second valid/ready handshake. It serves area-constrained PIM targets where a WIDTH-wide borrow chain is too costly and WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- A  in  WIDTH  minuend, sampled only on input handshake
- B  in  WIDTH  subtrahend, sampled only on input handshake
- out_valid  out  1  Sub (and Bout) hold a completed result
- out_ready  in  1  consumer accepts result
- Sub  out  WIDTH  result register; meaningful only while out_valid=1
- Bout  out  1  final borrow; present only with SUB_SEQ_BORROW_OUT_EN
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - load A/B shift registers
  - borrow←0, count←0
  - go to RUN
- RUN, each cycle, with a0=A_sr[0], b0=B_sr[0]:
  - d = a0^b0^borrow
  - borrow ← (~a0&b0) | (~(a0^b0)&borrow)
  - Sub ← {d, Sub[WIDTH-1:1]}
  - A_sr, B_sr shift right by 1
  - count++
  - When count==WIDTH-1, go to DONE. RUN lasts exactly WIDTH cycles.
- DONE: out_valid=1; Sub and borrow frozen. On out_ready, go to IDLE.
- Arithmetic: Sub = (A − B) mod 2^WIDTH, unsigned. Final borrow = 1 iff A < B.
- Ignored inputs:
  - in_valid outside IDLE; A/B are not re-sampled.
  - out_ready outside DONE.
- Count width is $clog2(WIDTH), minimum 1 bit. WIDTH=1 gives a single RUN cycle.
- No abort. Only reset cancels an operation.

## Timing
- Reset (async, any state):
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - Sub=0, Bout=0, borrow=0, count=0
- Reset mid-RUN or mid-DONE drops the transaction; no out_valid follows.
- Latency: input handshake at edge t0 → out_valid=1 after edge t0+WIDTH.
- out_valid and Sub hold stable until the edge where out_ready=1. The state is IDLE after that edge.
- Minimum issue interval: WIDTH+2 cycles. in_ready rises the cycle after the output handshake; there is no same-cycle bypass.
- Sub is visibly shifting during RUN. Consumers must qualify it with out_valid.
- All outputs are registered or decoded from state only; there is no combinational input→output path.

## Configuration
- SUB_SEQ_BORROW_OUT_EN defined:
  - Bout port exists and equals the final borrow while out_valid=1.
  - Bout is held with Sub and cleared by reset.
  - During RUN, Bout holds its previous value; it updates on entry to DONE.
- SUB_SEQ_BORROW_OUT_EN undefined:
  - No Bout port.
  - The borrow flop is still present internally. Sub behaviour is identical.

## Test plan
- WIDTH=8, A=0x05, B=0x03, out_ready=1 → out_valid 8 cycles after accept, Sub=0x02, Bout=0; in_ready high again 1 cycle after output handshake.
- WIDTH=8, A=0x03, B=0x05 → Sub=0xFE, Bout=1. Then A=0x00, B=0x01 → Sub=0xFF, Bout=1. Then A=0xFF, B=0xFF → Sub=0x00, Bout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → Sub, Bout, out_valid stable, in_ready=0. A new in_valid with A=0x11 is not accepted and the result is unchanged.
- Reset mid-operation: assert rst_n=0 at RUN bit 3 → immediately in_ready=1, out_valid=0, Sub=0. Next op A=0x80, B=0x01 → Sub=0x7F.
- Back-to-back: in_valid held high with 4 operand pairs, out_ready=1 → accepts spaced exactly WIDTH+2 cycles apart, results in order, randomized check against (A−B) mod 256.
- WIDTH=1: A=0, B=1 → Sub=1, Bout=1 after 1 RUN cycle. A=1, B=1 → Sub=0, Bout=0.
